// File: rtl/alu_issue_ctrl.sv
// Issue controller for a multi-cycle MIPS datapath: decodes one instruction per handshake, drives an
// external ALU from a 32x32 register file, captures result/flags and writes the result back.
`timescale 1ns/1ps
module alu_issue_ctrl #(
  parameter int RF_DEPTH = 32,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  input  logic [31:0]   instr,
  output logic          instr_ready,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_aluc,
  input  logic [DW-1:0] alu_r,
  input  logic          alu_zero,
  input  logic          alu_carry,
  input  logic          alu_negative,
  input  logic          alu_overflow,
  output logic          wb_valid,
  output logic [4:0]    wb_addr,
  output logic [DW-1:0] wb_data,
  output logic [3:0]    flags,
  output logic          illegal,
  output logic          ovf_trap,
  input  logic [4:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, ERR} state_t;

  state_t state, state_nx;

  logic [31:0]   instr_q;
  logic [DW-1:0] regs [RF_DEPTH];
  logic [DW-1:0] result_q;
  logic          trap_op_q;
  logic          trap_q;

  logic [5:0]    opcode, funct;
  logic [4:0]    rs, rt, rd, shamt;
  logic [15:0]   imm;
  logic          dec_legal, dec_trap_op;
  logic [3:0]    dec_aluc;
  logic [DW-1:0] dec_a, dec_b;
  logic [4:0]    dec_dest;

  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign shamt  = instr_q[10:6];
  assign funct  = instr_q[5:0];
  assign imm    = instr_q[15:0];

  // Decode the held instruction; anything not listed leaves dec_legal low and routes to ERR.
  always_comb begin
    dec_legal   = 1'b0;
    dec_trap_op = 1'b0;
    dec_aluc    = 4'b0000;
    dec_a       = regs[rs];
    dec_b       = regs[rt];
    dec_dest    = rd;
    if (opcode == 6'h00) begin
      dec_legal = 1'b1;
      case (funct)
        6'h20: begin dec_aluc = 4'b0010; dec_trap_op = 1'b1; end
        6'h21: dec_aluc = 4'b0000;
        6'h22: begin dec_aluc = 4'b0011; dec_trap_op = 1'b1; end
        6'h23: dec_aluc = 4'b0001;
        6'h24: dec_aluc = 4'b0100;
        6'h25: dec_aluc = 4'b0101;
        6'h26: dec_aluc = 4'b0110;
        6'h27: dec_aluc = 4'b0111;
        6'h2A: dec_aluc = 4'b1011;
        6'h2B: dec_aluc = 4'b1010;
        6'h00: begin dec_aluc = 4'b1110; dec_a = {27'b0, shamt}; end
        6'h02: begin dec_aluc = 4'b1101; dec_a = {27'b0, shamt}; end
        6'h03: begin dec_aluc = 4'b1100; dec_a = {27'b0, shamt}; end
        6'h04: dec_aluc = 4'b1110;
        6'h06: dec_aluc = 4'b1101;
        6'h07: dec_aluc = 4'b1100;
        default: dec_legal = 1'b0;
      endcase
    end else begin
      dec_legal = 1'b1;
      dec_dest  = rt;
      case (opcode)
        6'h08: begin dec_aluc = 4'b0010; dec_b = {{16{imm[15]}}, imm}; dec_trap_op = 1'b1; end
        6'h09: begin dec_aluc = 4'b0000; dec_b = {{16{imm[15]}}, imm}; end
        6'h0A: begin dec_aluc = 4'b1011; dec_b = {{16{imm[15]}}, imm}; end
        6'h0B: begin dec_aluc = 4'b1010; dec_b = {{16{imm[15]}}, imm}; end
        6'h0C: begin dec_aluc = 4'b0100; dec_b = {16'b0, imm}; end
        6'h0D: begin dec_aluc = 4'b0101; dec_b = {16'b0, imm}; end
        6'h0E: begin dec_aluc = 4'b0110; dec_b = {16'b0, imm}; end
        6'h0F: begin dec_aluc = 4'b1000; dec_b = {16'b0, imm}; end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (instr_valid) state_nx = DECODE;
      DECODE:  state_nx = dec_legal ? EXEC : ERR;
      EXEC:    state_nx = WB;
      WB:      state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign instr_ready = (state == IDLE);
  assign wb_valid    = (state == WB) && !trap_q;
  assign ovf_trap    = (state == WB) && trap_q;
  assign illegal     = (state == ERR);
  assign wb_data     = result_q;
  assign dbg_data    = regs[dbg_addr];

  // Register 0 is never written, so it reads as zero without a special read mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_aluc  <= '0;
      wb_addr   <= '0;
      result_q  <= '0;
      flags     <= '0;
      trap_op_q <= 1'b0;
      trap_q    <= 1'b0;
      for (int i = 0; i < RF_DEPTH; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: if (instr_valid) instr_q <= instr;
        DECODE: if (dec_legal) begin
          alu_a     <= dec_a;
          alu_b     <= dec_b;
          alu_aluc  <= dec_aluc;
          wb_addr   <= dec_dest;
          trap_op_q <= dec_trap_op;
        end
        EXEC: begin
          result_q <= alu_r;
          flags    <= {alu_zero, alu_carry, alu_negative, alu_overflow};
          trap_q   <= trap_op_q & alu_overflow;
        end
        WB: if (!trap_q && wb_addr != 5'd0) regs[wb_addr] <= result_q;
        default: ;
      endcase
    end
  end

endmodule
